// File: rtl/enc_serial_hamming_if.sv
// Handshake bundle for the bit-serial extended-Hamming encoder.
//   in_valid / in_ready   : info word hand-off (data_in, work_mod)
//   out_valid / out_ready : codeword hand-off (data_out, out_mod)
//   err_mode              : one-cycle pulse when an illegal-mode word is dropped
// The master modport is the side that supplies info words and consumes
// codewords; the slave modport is the encoder itself.
interface enc_serial_hamming_if #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26
);
    logic                          in_valid;
    logic                          in_ready;
    logic [MAX_INFO_WIDTH-1:0]     data_in;
    logic [1:0]                    work_mod;
    logic                          out_valid;
    logic                          out_ready;
    logic [MAX_CODEWORD_WIDTH-1:0] data_out;
    logic [1:0]                    out_mod;
    logic                          err_mode;

    modport master (
        output in_valid, data_in, work_mod, out_ready,
        input  in_ready, out_valid, data_out, out_mod, err_mode
    );

    modport slave (
        input  in_valid, data_in, work_mod, out_ready,
        output in_ready, out_valid, data_out, out_mod, err_mode
    );
endinterface

// File: rtl/enc_serial_hamming.sv
// Bit-serial extended-Hamming encoder, modes (8,4), (16,11) and (32,26).
// One info bit is folded into the parity accumulator per clock; the
// systematic codeword {zero pad, info[K-1:0], p[P-1:0]} is then held behind
// an out_valid/out_ready handshake.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : enc_serial_hamming_if.slave (input word handshake, codeword
//          handshake, out_mod and err_mode)
module enc_serial_hamming #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26
) (
    input  logic                   clk,
    input  logic                   rst,
    enc_serial_hamming_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, FINAL, HOLD} state_t;

    state_t                        state;
    logic [MAX_INFO_WIDTH-1:0]     info;
    logic [1:0]                    mode;
    logic [4:0]                    k_len;
    logic [2:0]                    r_len;
    logic [4:0]                    j;
    logic [5:0]                    pos;
    logic [4:0]                    p_acc;

    logic                          in_legal;
    logic [4:0]                    in_k;
    logic [2:0]                    in_r;
    logic [MAX_INFO_WIDTH-1:0]     in_mask;
    logic [5:0]                    pos_inc;
    logic [5:0]                    pos_next;
    logic                          overall;
    logic [MAX_CODEWORD_WIDTH-1:0] codeword;

    // Mode decode of the word currently offered, including the mask that
    // clears info bits at and above K.
    always_comb begin
        in_legal = 1'b1;
        in_k     = 5'd4;
        in_r     = 3'd3;
        in_mask  = '0;
        case (bus.work_mod)
            2'b00:   begin in_k = 5'd4;  in_r = 3'd3; end
            2'b01:   begin in_k = 5'd11; in_r = 3'd4; end
            2'b10:   begin in_k = 5'd26; in_r = 3'd5; end
            default: begin in_legal = 1'b0; end
        endcase
        for (int b = 0; b < MAX_INFO_WIDTH; b++) begin
            in_mask[b] = (b < int'(in_k));
        end
    end

    // Next codeword position skips powers of two (those slots hold parity).
    // Since pos never skips two in a row, one step of lookahead suffices.
    always_comb begin
        pos_inc  = pos + 6'd1;
        pos_next = ((pos_inc & (pos_inc - 6'd1)) == 6'd0) ? (pos + 6'd2) : pos_inc;
    end

    // Final codeword assembly. pos never exceeds 2^r - 1 in any mode, so
    // p_acc bits at and above r stay zero and can be folded in unmasked.
    always_comb begin
        overall  = (^info) ^ (^p_acc);
        codeword = (MAX_CODEWORD_WIDTH'(info) << (r_len + 3'd1))
                 | (MAX_CODEWORD_WIDTH'(overall) << r_len)
                 | MAX_CODEWORD_WIDTH'(p_acc);
    end

    // Control FSM with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.data_out  <= '0;
            bus.out_mod   <= 2'b00;
            bus.err_mode  <= 1'b0;
            info          <= '0;
            mode          <= 2'b00;
            k_len         <= 5'd0;
            r_len         <= 3'd0;
            j             <= 5'd0;
            pos           <= 6'd0;
            p_acc         <= 5'd0;
        end else begin
            bus.err_mode <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (in_legal) begin
                            info         <= bus.data_in & in_mask;
                            mode         <= bus.work_mod;
                            k_len        <= in_k;
                            r_len        <= in_r;
                            p_acc        <= 5'd0;
                            j            <= 5'd0;
                            pos          <= 6'd3;
                            bus.in_ready <= 1'b0;
                            state        <= SHIFT;
                        end else begin
                            // Illegal mode: word is consumed and dropped.
                            bus.err_mode <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (info[j]) begin
                        p_acc <= p_acc ^ pos[4:0];
                    end
                    j   <= j + 5'd1;
                    pos <= pos_next;
                    if (j == k_len - 5'd1) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    bus.data_out  <= codeword;
                    bus.out_mod   <= mode;
                    bus.out_valid <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc_serial_hamming.sv
// Directed self-checking bench for enc_serial_hamming. Expected codewords
// are hand-computed constants; random words are checked with a syndrome /
// overall-parity decoder written independently of the encoder.
module tb_enc_serial_hamming;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    enc_serial_hamming_if bus ();

    enc_serial_hamming dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and let exactly one edge consume it.
    task automatic applyStimulus(input logic [1:0] mode, input logic [25:0] data);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            tick();
            guard++;
        end
        checkOutput("in_ready_before_send", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.work_mod = mode;
        bus.data_in  = data;
        tick();
        bus.in_valid = 1'b0;
        bus.data_in  = 26'd0;
        bus.work_mod = 2'b00;
    endtask

    task automatic waitValid(input int limit, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < limit) begin
            tick();
            lat++;
        end
    endtask

    task automatic popWord(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic runWord(input string tag, input logic [1:0] mode, input logic [25:0] data,
                           input logic [31:0] exp_word, input int exp_lat);
        int lat;
        applyStimulus(mode, data);
        checkOutput({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        waitValid(60, lat);
        checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_word"}, bus.data_out, exp_word);
        checkOutput({tag, "_mod"}, 32'(bus.out_mod), 32'(mode));
        popWord(tag);
    endtask

    // Independent decoder: recompute the syndrome from the codeword bits.
    function automatic logic [31:0] syndromeOf(input logic [31:0] cw, input int k, input int p);
        logic [31:0] s;
        int          position;
        s        = 32'd0;
        position = 2;
        for (int jj = 0; jj < k; jj++) begin
            position++;
            if ((position & (position - 1)) == 0) position++;
            if (cw[p + jj]) s = s ^ 32'(position);
        end
        for (int i = 0; i < p - 1; i++) begin
            if (cw[i]) s = s ^ (32'd1 << i);
        end
        return s;
    endfunction

    task automatic roundTrip(input string tag, input logic [1:0] mode, input int k, input int p);
        logic [25:0] data;
        logic [31:0] mask;
        int          lat;
        data = 26'($urandom);
        mask = (32'd1 << k) - 32'd1;
        applyStimulus(mode, data);
        waitValid(60, lat);
        checkOutput({tag, "_lat"}, 32'(lat), 32'(k + 1));
        checkOutput({tag, "_syndrome"}, syndromeOf(bus.data_out, k, p), 32'd0);
        checkOutput({tag, "_parity"}, 32'(^bus.data_out), 32'd0);
        checkOutput({tag, "_info"}, bus.data_out >> p, 32'(data) & mask);
        popWord(tag);
    endtask

    initial begin
        int          highs;
        logic [31:0] held;
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.data_in   = 26'd0;
        bus.work_mod  = 2'b00;
        bus.out_ready = 1'b0;

        // T1: reset
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_data_out", bus.data_out, 32'd0);
        checkOutput("rst_err_mode", 32'(bus.err_mode), 32'd0);
        checkOutput("rst_out_mod", 32'(bus.out_mod), 32'd0);

        // T2-T4: directed codewords
        $display("[TB] directed codewords");
        runWord("m0_1", 2'b00, 26'h1, 32'h0000_001B, 5);
        runWord("m0_F", 2'b00, 26'hF, 32'h0000_00FF, 5);
        runWord("m1_1", 2'b01, 26'h001, 32'h0000_0033, 12);
        runWord("m1_mask", 2'b01, 26'h3FFF801, 32'h0000_0033, 12);
        runWord("m2_top", 2'b10, 26'h2000000, 32'h8000_001F, 27);

        // T4: random round trips through the independent decoder
        roundTrip("rt_m2a", 2'b10, 26, 6);
        roundTrip("rt_m2b", 2'b10, 26, 6);
        roundTrip("rt_m1", 2'b01, 11, 5);
        roundTrip("rt_m0", 2'b00, 4, 4);

        // T5: backpressure with a competing input word
        $display("[TB] backpressure and illegal mode");
        begin
            int lat;
            applyStimulus(2'b00, 26'hF);
            waitValid(60, lat);
            checkOutput("bp_lat", 32'(lat), 32'd5);
            held         = bus.data_out;
            bus.in_valid = 1'b1;
            bus.work_mod = 2'b01;
            bus.data_in  = 26'h7FF;
            for (int c = 0; c < 10; c++) begin
                tick();
                checkOutput("bp_stable", bus.data_out, 32'h0000_00FF);
                checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
            end
            checkOutput("bp_valid_held", 32'(bus.out_valid), 32'd1);
            bus.in_valid = 1'b0;
            popWord("bp");
            checkOutput("bp_data_kept", bus.data_out, held);
        end

        // T5: illegal mode, with out_ready high while nothing is valid
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.work_mod  = 2'b11;
        bus.data_in   = 26'h5;
        tick();
        bus.in_valid = 1'b0;
        bus.work_mod = 2'b00;
        checkOutput("ill_err_pulse", 32'(bus.err_mode), 32'd1);
        checkOutput("ill_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        checkOutput("ill_err_single", 32'(bus.err_mode), 32'd0);
        highs = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid) highs++;
            tick();
        end
        checkOutput("ill_no_valid", 32'(highs), 32'd0);
        checkOutput("ill_data_kept", bus.data_out, 32'h0000_00FF);
        bus.out_ready = 1'b0;

        // T6: reset in the middle of a mode10 word
        $display("[TB] reset mid-operation");
        applyStimulus(2'b10, 26'h1555555);
        for (int c = 0; c < 5; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_rst_data", bus.data_out, 32'd0);
        highs = 0;
        for (int c = 0; c < 35; c++) begin
            if (bus.out_valid) highs++;
            tick();
        end
        checkOutput("mid_rst_no_valid", 32'(highs), 32'd0);
        runWord("after_rst", 2'b00, 26'h1, 32'h0000_001B, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
